pwr_dn_seq: RTL
===============

# pwr_dn_seq

Power-down sequencer that brings the platform rails down in the reverse order of the master power-up sequencer. It sheds NIC/device power first, then the node 12 V rail, then optionally the 12 V AUX fan rail. Between steps it applies fixed dwell times and checks that the power-good signals actually drop. It sits beside the master sequencer: the master raises a shutdown request, this block drives force-off masks that the master ANDs into its enables, and it returns a done handshake plus active-low sequencing-fault flags.

## Interface
Parameters:
- TIMER_W, 16, width of the millisecond down-counter.
- DLY_DEV_MS, 10, dwell after device power is forced off, before the node rail is dropped.
- DLY_NODE_MS, 20, dwell after node power-good falls, before the fan step.
- DLY_FAN_MS, 1000, fan run-on time before the fan rail is dropped.
- PG_TIMEOUT_MS, 1000, maximum wait for a power-good to fall after its rail is forced off.

Ports:
- iClk, input, 1, module clock (2 MHz).
- iRst, input, 1, reset. Asynchronous, active-high.
- iTick_1ms, input, 1, one-iClk-wide pulse, once per ms, synchronous to iClk.
- iDn_Req, input, 1, level-sensitive shutdown request from the master sequencer.
- iEmergency, input, 1, leakage or emergency shutdown. Skips the device dwell.
- iFan_Keep, input, 1, 1 = leave the fan rail on at the end of the sequence.
- iFlt_Clr, input, 1, clears a latched fault.
- iPWRGD_P12V_Nodex, input, 1, node 12 V power-good.
- iPWRGD_P12V_AUX_FAN, input, 1, fan 12 V power-good.
- oDevices_Off, output, 1, 1 = force the device/NIC enable low.
- oNodex_Off, output, 1, 1 = force the NODEx, N1 and N2 enables low.
- oFan_Off, output, 1, 1 = force the AUX fan enable low.
- oDn_Done, output, 1, sequence finished (DONE or FAULT).
- oNodex_DN_FLT, output, 1, 0 = node power-good failed to fall. Latched.
- oFan_DN_FLT, output, 1, 0 = fan power-good failed to fall. Latched.
- oDBG_DN_FSM, output, 3, current state encoding.

## Operation
- States and encodings:
  - IDLE = 0
  - DEV_OFF = 1
  - NODE_OFF = 2
  - FAN_WAIT = 3
  - FAN_OFF = 4
  - DONE = 5
  - FAULT = 7
- IDLE: all Off outputs are 0.
  - iEmergency = 1: go to NODE_OFF. oDevices_Off and oNodex_Off are set in the same clock.
  - Otherwise, iDn_Req = 1: go to DEV_OFF and set oDevices_Off.
- DEV_OFF: timer counts DLY_DEV_MS. On expiry, go to NODE_OFF and set oNodex_Off.
  - iEmergency = 1 during DEV_OFF: go to NODE_OFF immediately.
- NODE_OFF: wait for iPWRGD_P12V_Nodex = 0.
  - While waiting, the timer runs PG_TIMEOUT_MS. If it expires with power-good still 1: oNodex_DN_FLT goes to 0 and the FSM goes to FAULT.
  - Once power-good reads 0, the timer reloads DLY_NODE_MS. A power-good glitch back to 1 during this dwell does not restart it.
  - On dwell expiry: iFan_Keep = 1 goes to DONE; otherwise go to FAN_WAIT.
- FAN_WAIT: timer counts DLY_FAN_MS. On expiry, go to FAN_OFF and set oFan_Off.
  - iFan_Keep rising during FAN_WAIT: go to DONE with oFan_Off left at 0.
- FAN_OFF: wait for iPWRGD_P12V_AUX_FAN = 0, with a PG_TIMEOUT_MS timeout. Power-good low goes to DONE. Timeout sets oFan_DN_FLT to 0 and goes to FAULT.
- DONE: oDn_Done = 1 and all Off outputs hold. iDn_Req = 0 and iEmergency = 0 go to IDLE, clearing all Off outputs and oDn_Done.
- FAULT: all Off outputs are forced to 1 (fan off included, regardless of iFan_Keep) and oDn_Done = 1. iFlt_Clr = 1 with iDn_Req = 0 goes to IDLE and restores both fault flags to 1.
- Requests during a sequence: iDn_Req dropping mid-sequence is ignored, and the sequence always completes. iEmergency outside IDLE and DEV_OFF is ignored, since the rails are already shedding.

## Timing
- Reset values:
  - FSM = IDLE.
  - oDevices_Off, oNodex_Off, oFan_Off and oDn_Done = 0.
  - oNodex_DN_FLT and oFan_DN_FLT = 1.
  - Timer = 0.
- Every transition and output update takes effect on the iClk edge after the qualifying input is sampled (1-cycle latency). Inputs are already synchronous.
- Timer behaviour:
  - Loaded with N in the cycle of state entry.
  - Decrements only on iTick_1ms.
  - Expires in the cycle where the count is 0 and iTick_1ms = 1.
  - Elapsed time is therefore N to N+1 ms.
  - N = 0 expires on the first tick after entry.
  - The counter saturates at 0 and never wraps.
- Off outputs are registered and glitch-free. Once set, an Off output is never cleared except on the DONE/FAULT-to-IDLE transition or on reset.
- Reset mid-sequence: all Off outputs return to 0 asynchronously. The master sequencer's own reset keeps the rails off.
- iDn_Req and iEmergency both high in IDLE: the emergency path wins.

## Test plan
- Normal shutdown, iFan_Keep = 0:
  - iDn_Req = 1 → oDevices_Off at +1 clk.
  - oNodex_Off after 10 ticks.
  - Node power-good drops at tick 5 → FAN_WAIT 20 ticks later.
  - oFan_Off after 1000 ticks; fan power-good drops → oDn_Done = 1 and state = 5.
- iFan_Keep = 1: after the node dwell → DONE with oFan_Off = 0. Dropping iDn_Req → IDLE and all outputs 0.
- iEmergency in IDLE → oDevices_Off = oNodex_Off = 1 on the same clock and state = 2. No DEV_OFF dwell.
- Node power-good held at 1 → after 1000 ticks oNodex_DN_FLT = 0, state = 7 and all Off = 1. iFlt_Clr with iDn_Req = 0 → IDLE and the flag returns to 1.
- Fan power-good stuck at 1 in FAN_OFF → oFan_DN_FLT = 0 and FAULT. iFlt_Clr while iDn_Req = 1 → FSM stays in FAULT.
- Assert iRst during FAN_WAIT → all Off outputs go to 0 without waiting for a clock edge and state = 0. Drop iDn_Req mid-DEV_OFF → the sequence still reaches DONE.

Source files
------------

// File: rtl/pwr_dn_seq.sv
// Power-down sequencer: sheds device, node and AUX fan rails in reverse power-up order,
// with dwell timers and power-good fall checks, driving force-off masks to the master.
module pwr_dn_seq #(
  parameter int unsigned TIMER_W       = 16,
  parameter int unsigned DLY_DEV_MS    = 10,
  parameter int unsigned DLY_NODE_MS   = 20,
  parameter int unsigned DLY_FAN_MS    = 1000,
  parameter int unsigned PG_TIMEOUT_MS = 1000
) (
  input  logic       iClk,
  input  logic       iRst,
  input  logic       iTick_1ms,
  input  logic       iDn_Req,
  input  logic       iEmergency,
  input  logic       iFan_Keep,
  input  logic       iFlt_Clr,
  input  logic       iPWRGD_P12V_Nodex,
  input  logic       iPWRGD_P12V_AUX_FAN,
  output logic       oDevices_Off,
  output logic       oNodex_Off,
  output logic       oFan_Off,
  output logic       oDn_Done,
  output logic       oNodex_DN_FLT,
  output logic       oFan_DN_FLT,
  output logic [2:0] oDBG_DN_FSM
);

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StDevOff  = 3'd1,
    StNodeOff = 3'd2,
    StFanWait = 3'd3,
    StFanOff  = 3'd4,
    StDone    = 3'd5,
    StFault   = 3'd7
  } state_e;

  localparam logic [TIMER_W-1:0] LdDev  = TIMER_W'(DLY_DEV_MS);
  localparam logic [TIMER_W-1:0] LdNode = TIMER_W'(DLY_NODE_MS);
  localparam logic [TIMER_W-1:0] LdFan  = TIMER_W'(DLY_FAN_MS);
  localparam logic [TIMER_W-1:0] LdPgTo = TIMER_W'(PG_TIMEOUT_MS);

  state_e               state_q, state_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic                 dwell_q, dwell_d;
  logic                 dev_off_q, dev_off_d;
  logic                 node_off_q, node_off_d;
  logic                 fan_off_q, fan_off_d;
  logic                 done_q, done_d;
  logic                 node_flt_n_q, node_flt_n_d;
  logic                 fan_flt_n_q, fan_flt_n_d;

  logic                 timer_exp;
  logic [TIMER_W-1:0]   timer_dec;
  logic                 to_idle;

  assign timer_exp = iTick_1ms && (timer_q == '0);
  assign timer_dec = (iTick_1ms && (timer_q != '0)) ? timer_q - TIMER_W'(1) : timer_q;

  // State register and all registered outputs.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_q      <= StIdle;
      timer_q      <= '0;
      dwell_q      <= 1'b0;
      dev_off_q    <= 1'b0;
      node_off_q   <= 1'b0;
      fan_off_q    <= 1'b0;
      done_q       <= 1'b0;
      node_flt_n_q <= 1'b1;
      fan_flt_n_q  <= 1'b1;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      dwell_q      <= dwell_d;
      dev_off_q    <= dev_off_d;
      node_off_q   <= node_off_d;
      fan_off_q    <= fan_off_d;
      done_q       <= done_d;
      node_flt_n_q <= node_flt_n_d;
      fan_flt_n_q  <= fan_flt_n_d;
    end
  end

  // Next-state and timer. dwell_q splits NODE_OFF into the power-good wait and the
  // post-drop dwell so a power-good glitch cannot restart the dwell.
  always_comb begin
    state_d = state_q;
    timer_d = timer_dec;
    dwell_d = dwell_q;
    unique case (state_q)
      StIdle: begin
        timer_d = '0;
        dwell_d = 1'b0;
        if (iEmergency) begin
          state_d = StNodeOff;
          timer_d = LdPgTo;
        end else if (iDn_Req) begin
          state_d = StDevOff;
          timer_d = LdDev;
        end
      end
      StDevOff: begin
        if (iEmergency || timer_exp) begin
          state_d = StNodeOff;
          timer_d = LdPgTo;
          dwell_d = 1'b0;
        end
      end
      StNodeOff: begin
        if (!dwell_q) begin
          if (!iPWRGD_P12V_Nodex) begin
            dwell_d = 1'b1;
            timer_d = LdNode;
          end else if (timer_exp) begin
            state_d = StFault;
          end
        end else if (timer_exp) begin
          dwell_d = 1'b0;
          if (iFan_Keep) begin
            state_d = StDone;
          end else begin
            state_d = StFanWait;
            timer_d = LdFan;
          end
        end
      end
      StFanWait: begin
        if (iFan_Keep) begin
          state_d = StDone;
        end else if (timer_exp) begin
          state_d = StFanOff;
          timer_d = LdPgTo;
        end
      end
      StFanOff: begin
        if (!iPWRGD_P12V_AUX_FAN) begin
          state_d = StDone;
        end else if (timer_exp) begin
          state_d = StFault;
        end
      end
      StDone: begin
        timer_d = '0;
        if (!iDn_Req && !iEmergency) state_d = StIdle;
      end
      StFault: begin
        timer_d = '0;
        if (iFlt_Clr && !iDn_Req) state_d = StIdle;
      end
      default: begin
        // Unused encoding 6: fail safe with every rail forced off.
        state_d = StFault;
        timer_d = '0;
      end
    endcase
  end

  // Off masks only ever set on a transition; they clear solely on DONE/FAULT -> IDLE.
  always_comb begin
    to_idle      = (state_q == StDone || state_q == StFault) && (state_d == StIdle);
    dev_off_d    = dev_off_q | (state_d != StIdle);
    node_off_d   = node_off_q | (state_d == StNodeOff) | (state_d == StFault);
    fan_off_d    = fan_off_q | (state_d == StFanOff) | (state_d == StFault);
    done_d       = done_q | (state_d == StDone) | (state_d == StFault);
    node_flt_n_d = node_flt_n_q & ~((state_q == StNodeOff) && (state_d == StFault));
    fan_flt_n_d  = fan_flt_n_q & ~((state_q == StFanOff) && (state_d == StFault));
    if (to_idle) begin
      dev_off_d  = 1'b0;
      node_off_d = 1'b0;
      fan_off_d  = 1'b0;
      done_d     = 1'b0;
      if (state_q == StFault) begin
        node_flt_n_d = 1'b1;
        fan_flt_n_d  = 1'b1;
      end
    end
  end

  assign oDevices_Off  = dev_off_q;
  assign oNodex_Off    = node_off_q;
  assign oFan_Off      = fan_off_q;
  assign oDn_Done      = done_q;
  assign oNodex_DN_FLT = node_flt_n_q;
  assign oFan_DN_FLT   = fan_flt_n_q;
  assign oDBG_DN_FSM   = state_q;

endmodule
